// File: rtl/step_sequencer.sv
// step_sequencer: autonomous pattern player for the synth voice.
// A small pattern RAM holds note periods; on a prescaled tick grid the FSM
// walks the pattern and drives osc_count / trig / step_idx / step_stb.
// Optional feature: define SEQ_SWING_EN to add the swing[7:0] input, which
// lengthens every odd-index step by swing ticks.
module step_sequencer #(
    parameter int STEPS    = 16,
    parameter int TICK_DIV = 20480,
    parameter int CW       = 12,
    localparam int SW      = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [15:0]   step_len,
    input  logic [15:0]   gate_len,
    input  logic [SW-1:0] last_step,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
    input  logic [CW-1:0] wr_note,
`ifdef SEQ_SWING_EN
    input  logic [7:0]    swing,
`endif
    output logic [CW-1:0] osc_count,
    output logic          trig,
    output logic [SW-1:0] step_idx,
    output logic          step_stb
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        GATE  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] ram_r [STEPS];
    logic [PW-1:0] pre_r;
    logic [PW-1:0] pre_inc_s;
    logic          tick_s;
    logic [16:0]   gate_cnt_r;
    logic [16:0]   step_cnt_r;
    logic [16:0]   swing_add_s;
    logic [16:0]   step_target_s;
    logic          step_end_s;
    logic          gate_end_s;
    logic [CW-1:0] note_s;
    logic [SW-1:0] next_idx_s;
    logic [CW-1:0] osc_nxt_s;
    logic          trig_nxt_s;
    logic [SW-1:0] idx_nxt_s;
    logic          stb_nxt_s;

    // Pattern RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_r[wr_addr] <= wr_note;
        end else begin
            ram_r[wr_addr] <= ram_r[wr_addr];
        end
    end

    // Derived step timing: tick strobe, effective step length, step/gate end and next index.
    always_comb begin
        pre_inc_s = (pre_r == PRE_MAX) ? {PW{1'b0}} : (pre_r + PW'(1));
        tick_s    = (pre_r == PRE_MAX);
`ifdef SEQ_SWING_EN
        swing_add_s = step_idx[0] ? {9'd0, swing} : 17'd0;
`else
        swing_add_s = 17'd0;
`endif
        step_target_s = ((step_len == 16'd0) ? 17'd1 : {1'b0, step_len}) + swing_add_s;
        step_end_s    = tick_s && ((step_cnt_r + 17'd1) >= step_target_s);
        gate_end_s    = (gate_cnt_r >= {1'b0, gate_len});
        note_s        = ram_r[step_idx];
        next_idx_s    = (step_idx == last_step) ? {SW{1'b0}} : (step_idx + SW'(1));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; dropping run returns to IDLE from anywhere.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = run ? START : IDLE;
            START:   state_nxt_s = GATE;
            GATE: begin
                if (step_end_s) begin
                    state_nxt_s = GAP;
                end else if (gate_end_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = GATE;
                end
            end
            HOLD:    state_nxt_s = step_end_s ? GAP : HOLD;
            GAP:     state_nxt_s = START;
            default: state_nxt_s = IDLE;
        endcase
        if (!run) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // FSM output logic: next values for the registered outputs.
    always_comb begin
        osc_nxt_s  = osc_count;
        trig_nxt_s = trig;
        idx_nxt_s  = step_idx;
        stb_nxt_s  = 1'b0;
        if ((state_r != IDLE) && !run) begin
            trig_nxt_s = 1'b0;
            idx_nxt_s  = {SW{1'b0}};
        end else begin
            case (state_r)
                START: begin
                    // A rest keeps the previous pitch and stays silent.
                    if (note_s != {CW{1'b0}}) begin
                        osc_nxt_s = note_s;
                    end else begin
                        osc_nxt_s = osc_count;
                    end
                    trig_nxt_s = (note_s != {CW{1'b0}}) && (gate_len != 16'd0);
                    stb_nxt_s  = 1'b1;
                end
                GATE: begin
                    if (step_end_s) begin
                        idx_nxt_s = next_idx_s;
                    end else if (gate_end_s) begin
                        trig_nxt_s = 1'b0;
                    end else begin
                        trig_nxt_s = trig;
                    end
                end
                HOLD: begin
                    if (step_end_s) begin
                        idx_nxt_s = next_idx_s;
                    end else begin
                        idx_nxt_s = step_idx;
                    end
                end
                // Forced low so the next step always produces a fresh rising edge.
                GAP:     trig_nxt_s = 1'b0;
                default: trig_nxt_s = trig;
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            osc_count <= {CW{1'b0}};
            trig      <= 1'b0;
            step_idx  <= {SW{1'b0}};
            step_stb  <= 1'b0;
        end else begin
            osc_count <= osc_nxt_s;
            trig      <= trig_nxt_s;
            step_idx  <= idx_nxt_s;
            step_stb  <= stb_nxt_s;
        end
    end

    // Prescaler and tick counters; prescaler restarts at every step start for repeatable timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r      <= {PW{1'b0}};
            gate_cnt_r <= 17'd0;
            step_cnt_r <= 17'd0;
        end else begin
            case (state_r)
                START: begin
                    pre_r      <= pre_inc_s;
                    gate_cnt_r <= 17'd0;
                    step_cnt_r <= 17'd0;
                end
                GATE: begin
                    pre_r <= pre_inc_s;
                    if (tick_s) begin
                        gate_cnt_r <= gate_cnt_r + 17'd1;
                        step_cnt_r <= step_cnt_r + 17'd1;
                    end else begin
                        gate_cnt_r <= gate_cnt_r;
                        step_cnt_r <= step_cnt_r;
                    end
                end
                HOLD: begin
                    pre_r <= pre_inc_s;
                    if (tick_s) begin
                        step_cnt_r <= step_cnt_r + 17'd1;
                    end else begin
                        step_cnt_r <= step_cnt_r;
                    end
                end
                default: begin
                    pre_r <= {PW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer (TICK_DIV=4): directed scenarios with literal
// expectations plus randomized play checked every cycle against a
// step-timeline model (each step lasts 4*len+1 clks, trig high 4*min(gate,len)).
module tb_step_sequencer;
    localparam int STEPS = 16;
    localparam int TD    = 4;
    localparam int CW    = 12;
    localparam int SW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [15:0]   step_len;
    logic [15:0]   gate_len;
    logic [SW-1:0] last_step;
    logic          wr_en;
    logic [SW-1:0] wr_addr;
    logic [CW-1:0] wr_note;
`ifdef SEQ_SWING_EN
    logic [7:0]    swing;
`endif
    logic [CW-1:0] osc_count;
    logic          trig;
    logic [SW-1:0] step_idx;
    logic          step_stb;

    step_sequencer #(.STEPS(STEPS), .TICK_DIV(TD), .CW(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .step_len(step_len), .gate_len(gate_len),
        .last_step(last_step), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
`ifdef SEQ_SWING_EN
        .swing(swing),
`endif
        .osc_count(osc_count), .trig(trig), .step_idx(step_idx), .step_stb(step_stb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: m_s = clks since this step's START cycle, step lasts m_P clks.
    logic [CW-1:0] m_ram [STEPS];
    bit  m_act = 1'b0;
    int  m_osc = 0, m_trig = 0, m_idx = 0, m_stb = 0;
    int  m_s = 0, m_k = 0, m_kn = 0, m_P = 0, m_H = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int s_new, len, g, note;
        if (rst) begin
            m_act = 1'b0; m_osc = 0; m_trig = 0; m_idx = 0; m_stb = 0;
        end else if (m_act && !run) begin
            m_act = 1'b0; m_trig = 0; m_idx = 0; m_stb = 0;
        end else if (!m_act) begin
            m_stb = 0;
            if (run) begin
                m_act = 1'b1; m_k = 0; m_s = 0;
            end
        end else begin
            s_new = m_s + 1;
            m_stb = 0;
            if (s_new == 1) begin
                note = int'(m_ram[m_k]);
                len  = (step_len == 16'd0) ? 1 : int'(step_len);
`ifdef SEQ_SWING_EN
                if (m_k % 2 == 1) len = len + int'(swing);
`endif
                g    = int'(gate_len);
                m_P  = TD * len + 1;
                m_H  = (note != 0 && g != 0) ? TD * ((g < len) ? g : len) : 0;
                m_stb = 1;
                if (note != 0) m_osc = note;
            end
            if (s_new == m_P) begin
                m_s = 0; m_k = m_kn; m_trig = 0;
            end else begin
                m_s = s_new;
                m_trig = (s_new <= m_H) ? 1 : 0;
                if (s_new == m_P - 1) begin
                    m_kn  = (m_k == int'(last_step)) ? 0 : (m_k + 1) % STEPS;
                    m_idx = m_kn;
                end
            end
        end
        if (wr_en) m_ram[wr_addr] = wr_note;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("osc_count", int'(osc_count), m_osc);
        chk("trig", int'(trig), m_trig);
        chk("step_idx", int'(step_idx), m_idx);
        chk("step_stb", int'(step_stb), m_stb);
    endtask

    task automatic wr(input int a, input int n);
        wr_en = 1'b1; wr_addr = 4'(a); wr_note = 12'(n);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic stop_run();
        run = 1'b0;
        tick();
        tick();
    endtask

    int exp_osc [3] = '{200, 300, 100};
    int exp_idx [3] = '{1, 2, 0};
    int hi, stbs, lows, n;

    initial begin
        rst = 1'b1; run = 1'b0; step_len = 16'd3; gate_len = 16'd2; last_step = 4'd2;
        wr_en = 1'b0; wr_addr = 4'd0; wr_note = 12'd0;
`ifdef SEQ_SWING_EN
        swing = 8'd0;
`endif
        tick();
        tick();
        chk("reset_osc", int'(osc_count), 0);
        chk("reset_trig", int'(trig), 0);
        chk("reset_idx", int'(step_idx), 0);
        chk("reset_stb", int'(step_stb), 0);
        rst = 1'b0;
        for (int i = 0; i < STEPS; i++) wr(i, (i + 1) * 100);

        // Reset mid-GATE clears outputs on the next clock.
        run = 1'b1;
        repeat (5) tick();
        chk("t1_trig_before", int'(trig), 1);
        rst = 1'b1; run = 1'b0;
        tick();
        rst = 1'b0;
        chk("t1_trig", int'(trig), 0);
        chk("t1_osc", int'(osc_count), 0);
        chk("t1_idx", int'(step_idx), 0);
        chk("t1_stb", int'(step_stb), 0);
        tick();

        // Three-note loop: 13-clk steps, trig high 8 clks.
        run = 1'b1;
        tick();
        tick();
        chk("t2_first_stb", int'(step_stb), 1);
        chk("t2_first_osc", int'(osc_count), 100);
        for (int j = 0; j < 3; j++) begin
            hi = int'(trig);
            repeat (12) begin
                tick();
                hi += int'(trig);
            end
            tick();
            chk("t2_trig_high", hi, 8);
            chk("t2_stb", int'(step_stb), 1);
            chk("t2_osc", int'(osc_count), exp_osc[j]);
            chk("t2_idx", int'(step_idx), exp_idx[j]);
        end
        stop_run();

        // Stop during step 2, then restart from step 0.
        run = 1'b1;
        tick();
        tick();
        repeat (26) tick();
        chk("t5_idx2", int'(step_idx), 2);
        repeat (2) tick();
        run = 1'b0;
        tick();
        chk("t5_trig", int'(trig), 0);
        chk("t5_idx", int'(step_idx), 0);
        chk("t5_osc_hold", int'(osc_count), 300);
        tick();
        run = 1'b1;
        tick();
        chk("t5_no_stb_yet", int'(step_stb), 0);
        tick();
        chk("t5_restart_stb", int'(step_stb), 1);
        chk("t5_restart_osc", int'(osc_count), 100);
        stop_run();

        // Gate longer than step: only the 1-clk gap separates steps.
        gate_len = 16'd5;
        run = 1'b1;
        stbs = 0; lows = 0;
        repeat (52) begin
            tick();
            stbs += int'(step_stb);
            lows += (trig == 1'b0) ? 1 : 0;
        end
        chk("t3_stb_count", stbs, 4);
        chk("t3_low_clks", lows, 4);
        stop_run();

        // Rest step keeps pitch and stays silent.
        wr(1, 0);
        last_step = 4'd1; step_len = 16'd2; gate_len = 16'd1;
        run = 1'b1;
        tick();
        tick();
        chk("t4_osc0", int'(osc_count), 100);
        repeat (8) tick();
        repeat (8) begin
            tick();
            chk("t4_rest_trig", int'(trig), 0);
            chk("t4_rest_osc", int'(osc_count), 100);
        end
        stop_run();
        wr(1, 200);

`ifdef SEQ_SWING_EN
        // Swing lengthens odd steps only.
        swing = 8'd2; step_len = 16'd3; gate_len = 16'd2; last_step = 4'd2;
        run = 1'b1;
        tick();
        tick();
        chk("t6_stb0", int'(step_stb), 1);
        repeat (13) tick();
        chk("t6_stb1", int'(step_stb), 1);
        chk("t6_idx1", int'(step_idx), 1);
        repeat (21) tick();
        chk("t6_stb2", int'(step_stb), 1);
        chk("t6_idx2", int'(step_idx), 2);
        stop_run();
        swing = 8'd0;
`endif

        // Randomized play against the model.
        for (int seg = 0; seg < 40; seg++) begin
            step_len  = 16'($urandom_range(0, 4));
            gate_len  = 16'($urandom_range(0, 6));
            last_step = 4'($urandom_range(0, 15));
`ifdef SEQ_SWING_EN
            swing = 8'($urandom_range(0, 3));
`endif
            repeat ($urandom_range(1, 3)) tick();
            run = 1'b1;
            n = $urandom_range(10, 150);
            repeat (n) begin
                wr_en   = ($urandom_range(0, 3) == 0);
                wr_addr = 4'($urandom_range(0, 15));
                wr_note = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
                rst     = ($urandom_range(0, 199) == 0);
                run     = ($urandom_range(0, 59) != 0);
                tick();
            end
            wr_en = 1'b0; rst = 1'b0; run = 1'b0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
